// File: rtl/spm_resp.sv
// spm_resp: scratch-pad memory responder for the bus_if <-> SPM interface.
// Accepts one word access per strobe, inserts WAIT_CYCLES wait states, then
// acknowledges with a single active-low spm_rdy_ cycle. Out-of-range word
// addresses complete normally but raise spm_err and never touch the array.
module spm_resp #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] spm_addr,
  input  logic        spm_as_,
  input  logic        spm_rw,
  input  logic [31:0] spm_wr_data,
  output logic [31:0] spm_rd_data,
  output logic        spm_rdy_,
  output logic        spm_err
);

  localparam int         DEPTH     = 1 << ADDR_W;
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic [29:0] addr_p0;
  logic        rw_p0;
  logic [31:0] wr_data_p0;
  logic [31:0] mem [DEPTH];

  logic [29:0]       acc_addr;
  logic              acc_rw;
  logic [31:0]       acc_wr_data;
  logic [ADDR_W-1:0] acc_idx;
  logic              acc_oor;
  logic              enter_ack;
  logic              mem_we;

  // Select the access being completed: live bus inputs when ACK follows the
  // strobe directly, otherwise the copy latched at the strobe.
  always_comb begin
    acc_addr    = addr_p0;
    acc_rw      = rw_p0;
    acc_wr_data = wr_data_p0;
    if (state == IDLE) begin
      acc_addr    = spm_addr;
      acc_rw      = spm_rw;
      acc_wr_data = spm_wr_data;
    end
    acc_idx   = acc_addr[ADDR_W-1:0];
    acc_oor   = (acc_addr >> ADDR_W) != 30'd0;
    enter_ack = 1'b0;
    if (!reset) begin
      if (state == IDLE) begin
        enter_ack = !spm_as_ && (WAIT_CYCLES == 0);
      end else if (state == WAIT) begin
        enter_ack = (wait_cnt == 4'd0);
      end
    end
    mem_we = enter_ack && !acc_rw && !acc_oor;
  end

  // Capture the request at the strobe so WAIT ignores later bus changes.
  always_ff @(posedge clk) begin
    if (state == IDLE && !spm_as_) begin
      addr_p0    <= spm_addr;
      rw_p0      <= spm_rw;
      wr_data_p0 <= spm_wr_data;
    end
  end

  // Word array: writes commit on the edge entering ACK; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[acc_idx] <= acc_wr_data;
    end
  end

  // Access sequencer with registered acknowledge, error and read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= 4'd0;
      spm_rdy_    <= 1'b1;
      spm_err     <= 1'b0;
      spm_rd_data <= '0;
    end else if (enter_ack) begin
      state       <= ACK;
      spm_rdy_    <= 1'b0;
      spm_err     <= acc_oor;
      spm_rd_data <= (acc_rw && !acc_oor) ? mem[acc_idx] : 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (!spm_as_) begin
            state    <= WAIT;
            wait_cnt <= WAIT_INIT;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
        end
        ACK: begin
          state       <= IDLE;
          spm_rdy_    <= 1'b1;
          spm_err     <= 1'b0;
          spm_rd_data <= '0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spm_resp.sv
// tb_spm_resp: drives two responders (0 and 3 wait states) from one bus and
// checks both every cycle against a transaction-level model, plus directed
// scenarios with hand-computed expectations.
module tb_spm_resp;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [29:0] spm_addr = '0;
  logic        spm_as_ = 1'b1;
  logic        spm_rw = 1'b1;
  logic [31:0] spm_wr_data = '0;
  logic [31:0] rd0, rd1;
  logic        rdy0, rdy1, err0, err1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  spm_resp #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .spm_addr(spm_addr), .spm_as_(spm_as_),
    .spm_rw(spm_rw), .spm_wr_data(spm_wr_data),
    .spm_rd_data(rd0), .spm_rdy_(rdy0), .spm_err(err0)
  );

  spm_resp #(.ADDR_W(10), .WAIT_CYCLES(3)) dut1 (
    .clk(clk), .reset(reset), .spm_addr(spm_addr), .spm_as_(spm_as_),
    .spm_rw(spm_rw), .spm_wr_data(spm_wr_data),
    .spm_rd_data(rd1), .spm_rdy_(rdy1), .spm_err(err1)
  );

  // Transaction model: one pending access per responder, acknowledged W edges
  // after the strobe edge, followed by one ACK cycle where strobes are ignored.
  logic [31:0] mm [2][1024];
  bit          busy [2];
  bit          ackp [2];
  int          ack_at [2];
  logic [29:0] p_addr [2];
  bit          p_rw [2];
  logic [31:0] p_data [2];
  logic [31:0] e_rd [2];
  bit          e_rdy [2];
  bit          e_err [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_idle(input int i);
    e_rdy[i] = 1'b1;
    e_err[i] = 1'b0;
    e_rd[i]  = 32'd0;
  endtask

  task automatic commit(input int i);
    bit oor;
    oor = (p_addr[i] >> 10) != 30'd0;
    ackp[i]  = 1'b1;
    e_rdy[i] = 1'b0;
    e_err[i] = oor;
    e_rd[i]  = 32'd0;
    if (!oor) begin
      if (p_rw[i]) e_rd[i] = mm[i][p_addr[i][9:0]];
      else         mm[i][p_addr[i][9:0]] = p_data[i];
    end
  endtask

  task automatic model_edge(input int i, input int w);
    if (reset) begin
      busy[i] = 1'b0;
      ackp[i] = 1'b0;
      set_idle(i);
    end else if (ackp[i]) begin
      ackp[i] = 1'b0;
      set_idle(i);
    end else if (busy[i]) begin
      if (cyc == ack_at[i]) begin
        busy[i] = 1'b0;
        commit(i);
      end else begin
        set_idle(i);
      end
    end else if (!spm_as_) begin
      p_addr[i] = spm_addr;
      p_rw[i]   = spm_rw;
      p_data[i] = spm_wr_data;
      if (w == 0) begin
        commit(i);
      end else begin
        busy[i]   = 1'b1;
        ack_at[i] = cyc + w;
        set_idle(i);
      end
    end else begin
      set_idle(i);
    end
  endtask

  // Per-cycle compare of both responders against the model.
  initial begin
    foreach (mm[i, j]) mm[i][j] = 'x;
    forever begin
      @(posedge clk);
      cyc++;
      model_edge(0, 0);
      model_edge(1, 3);
      #1;
      chk("rdy_w0", rdy0, e_rdy[0]);
      chk("err_w0", err0, e_err[0]);
      if (!$isunknown(e_rd[0])) chk("rd_w0", rd0, e_rd[0]);
      chk("rdy_w3", rdy1, e_rdy[1]);
      chk("err_w3", err1, e_err[1]);
      if (!$isunknown(e_rd[1])) chk("rd_w3", rd1, e_rd[1]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input bit as_n, input bit rw, input logic [29:0] a, input logic [31:0] d);
    spm_as_     = as_n;
    spm_rw      = rw;
    spm_addr    = a;
    spm_wr_data = d;
  endtask

  task automatic settle();
    drv(1'b1, 1'b1, 30'd0, 32'd0);
    repeat (8) tick();
  endtask

  task automatic pick_addr(output logic [29:0] a);
    int sel;
    sel = $urandom_range(0, 9);
    if (sel < 6)       a = 30'($urandom_range(0, 15));
    else if (sel == 6) a = 30'h3FF;
    else if (sel == 7) a = 30'h400;
    else               a = 30'($urandom) | 30'h400;
  endtask

  // Directed scenarios followed by randomized traffic.
  initial begin
    int acks;
    logic [29:0] a;

    reset = 1'b1;
    tick();
    tick();
    chk("reset_rdy_w0", rdy0, 1);
    chk("reset_rd_w0", rd0, 0);
    chk("reset_err_w0", err0, 0);
    chk("reset_rdy_w3", rdy1, 1);
    reset = 1'b0;

    // Write then read, no wait states
    drv(1'b0, 1'b0, 30'h55, 32'h59);
    tick();
    chk("t1_wr_rdy", rdy0, 0);
    chk("t1_wr_rd", rd0, 0);
    drv(1'b1, 1'b1, 30'd0, 32'd0);
    tick();
    chk("t1_gap_rdy", rdy0, 1);
    drv(1'b0, 1'b1, 30'h55, 32'd0);
    tick();
    chk("t1_rd_rdy", rdy0, 0);
    chk("t1_rd_data", rd0, 32'h59);
    drv(1'b1, 1'b1, 30'd0, 32'd0);
    tick();
    chk("t1_after_rd", rd0, 0);
    settle();

    // Idle bus
    drv(1'b1, 1'b1, 30'h55, 32'd0);
    repeat (5) begin
      tick();
      chk("t2_idle_rdy", rdy0, 1);
      chk("t2_idle_rd", rd0, 0);
    end

    // Three wait states
    drv(1'b0, 1'b1, 30'h55, 32'd0);
    tick();
    chk("t3_k0_rdy", rdy1, 1);
    drv(1'b1, 1'b0, 30'h12, 32'hDEAD);
    tick();
    chk("t3_k1_rdy", rdy1, 1);
    tick();
    chk("t3_k2_rdy", rdy1, 1);
    tick();
    chk("t3_ack_rdy", rdy1, 0);
    chk("t3_ack_rd", rd1, 32'h59);
    tick();
    chk("t3_post_rdy", rdy1, 1);
    chk("t3_post_rd", rd1, 0);
    settle();

    // Out of range write leaves word 0 intact
    drv(1'b0, 1'b0, 30'h000, 32'h11);
    tick();
    settle();
    drv(1'b0, 1'b0, 30'h400, 32'h24);
    tick();
    chk("t4_err", err0, 1);
    chk("t4_rdy", rdy0, 0);
    drv(1'b1, 1'b1, 30'd0, 32'd0);
    tick();
    chk("t4_err_gone", err0, 0);
    settle();
    drv(1'b0, 1'b1, 30'h000, 32'd0);
    tick();
    chk("t4_rd0", rd0, 32'h11);
    settle();

    // Highest valid index
    drv(1'b0, 1'b0, 30'h3FF, 32'hCAFE);
    tick();
    chk("top_wr_err", err0, 0);
    settle();
    drv(1'b0, 1'b1, 30'h3FF, 32'd0);
    tick();
    chk("top_rd", rd0, 32'hCAFE);
    settle();

    // Reset during WAIT aborts the write
    drv(1'b0, 1'b0, 30'h10, 32'h22);
    tick();
    settle();
    drv(1'b0, 1'b0, 30'h10, 32'hAB);
    tick();
    drv(1'b1, 1'b1, 30'd0, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (4) begin
      tick();
      chk("t5_no_ack", rdy1, 1);
    end
    drv(1'b0, 1'b1, 30'h10, 32'd0);
    tick();
    drv(1'b1, 1'b1, 30'd0, 32'd0);
    repeat (3) tick();
    chk("t5_rdy", rdy1, 0);
    chk("t5_old_val", rd1, 32'h22);
    settle();

    // Strobe held low: acknowledges in alternate cycles
    acks = 0;
    drv(1'b0, 1'b1, 30'h55, 32'd0);
    repeat (4) begin
      tick();
      if (!rdy0) acks++;
    end
    drv(1'b1, 1'b1, 30'd0, 32'd0);
    tick();
    if (!rdy0) acks++;
    chk("t6_ack_count", acks, 2);
    settle();

    // Populate the random address set, then random traffic
    for (int k = 0; k < 17; k++) begin
      drv(1'b0, 1'b0, (k == 16) ? 30'h3FF : 30'(k), $urandom);
      tick();
      drv(1'b1, 1'b1, 30'd0, 32'd0);
      repeat (5) tick();
    end
    for (int k = 0; k < 800; k++) begin
      pick_addr(a);
      reset = ($urandom_range(0, 99) == 0);
      drv($urandom_range(0, 9) < 3, 1'($urandom), a, $urandom);
      tick();
    end
    reset = 1'b0;
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
